muldiv_seq: RTL and testbench

//   Iterative RV32M multiply/divide sequencer beside the main ALU in the execute stage.

---
 rtl/muldiv_seq_if.sv | 25 ++
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_muldiv_seq.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Handshake bundle between the execute-stage control and the iterative
// multiply/divide sequencer: request side (start/op/operands/flush) and
// response side (busy/done/result).
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Operands are reduced to
// magnitudes on accept, one shift-add (multiply) or restoring-subtract
// (divide) step runs per cycle, and the sign is reapplied when the result
// is registered. Divide-by-zero and signed overflow use precomputed values.
module muldiv_seq #(
    parameter int XLEN      = 32,
    parameter bit FAST_SPEC = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, next_state;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q;
    logic              special_q;
    logic [XLEN-1:0]   special_val_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              accept;
    logic              is_div_in;
    logic              neg_a_in, neg_b_in;
    logic [XLEN-1:0]   mag_a_in, mag_b_in;
    logic              div_zero_in, ovf_in, special_in, fast_in, neg_res_in;
    logic [XLEN-1:0]   special_val_in;
    logic [XLEN:0]     mul_sum, shifted, diff;
    logic [2*XLEN-1:0] prod_next, prod_signed;
    logic [XLEN-1:0]   div_sel, calc_result;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Decode the incoming request and compute one iteration step plus the finished result.
    always_comb begin
        accept         = (state == IDLE) && bus.start && !bus.flush;
        is_div_in      = bus.op[2];
        neg_a_in       = bus.a[XLEN-1] && (bus.op == 3'b001 || bus.op == 3'b010 ||
                                           bus.op == 3'b100 || bus.op == 3'b110);
        neg_b_in       = bus.b[XLEN-1] && (bus.op == 3'b001 || bus.op == 3'b100 ||
                                           bus.op == 3'b110);
        mag_a_in       = neg_a_in ? -bus.a : bus.a;
        mag_b_in       = neg_b_in ? -bus.b : bus.b;
        div_zero_in    = is_div_in && (bus.b == '0);
        ovf_in         = is_div_in && !bus.op[0] && (bus.a == MIN_NEG) && (bus.b == '1);
        special_in     = div_zero_in || ovf_in;
        fast_in        = FAST_SPEC && special_in;
        neg_res_in     = (is_div_in && bus.op[1]) ? neg_a_in : (neg_a_in ^ neg_b_in);
        special_val_in = '0;
        if (div_zero_in) begin
            special_val_in = bus.op[1] ? bus.a : '1;
        end else if (ovf_in) begin
            special_val_in = bus.op[1] ? '0 : MIN_NEG;
        end

        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        shifted   = prod_q[2*XLEN-1:XLEN-1];
        diff      = shifted - {1'b0, opnd_q};
        prod_next = {mul_sum, prod_q[XLEN-1:1]};
        if (op_q[2]) begin
            prod_next = diff[XLEN] ? {shifted[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0],    prod_q[XLEN-2:0], 1'b1};
        end

        prod_signed = neg_q ? -prod_next : prod_next;
        div_sel     = op_q[1] ? prod_next[2*XLEN-1:XLEN] : prod_next[XLEN-1:0];
        if (special_q) begin
            calc_result = special_val_q;
        end else if (op_q[2]) begin
            calc_result = neg_q ? -div_sel : div_sel;
        end else if (op_q[1:0] == 2'b00) begin
            calc_result = prod_signed[XLEN-1:0];
        end else begin
            calc_result = prod_signed[2*XLEN-1:XLEN];
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; flush always returns to IDLE and beats a same-cycle start.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = fast_in ? DONE : CALC;
            CALC:    if (cnt_q == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.flush) begin
            next_state = IDLE;
        end
    end

    // Operand capture, iteration datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q          <= '0;
            opnd_q        <= '0;
            prod_q        <= '0;
            neg_q         <= 1'b0;
            special_q     <= 1'b0;
            special_val_q <= '0;
            cnt_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
        end else begin
            busy_q <= (next_state != IDLE);
            done_q <= (next_state == DONE);
            if (accept) begin
                op_q          <= bus.op;
                opnd_q        <= is_div_in ? mag_b_in : mag_a_in;
                prod_q        <= {{XLEN{1'b0}}, (is_div_in ? mag_a_in : mag_b_in)};
                neg_q         <= neg_res_in;
                special_q     <= special_in;
                special_val_q <= special_val_in;
                cnt_q         <= '0;
                if (fast_in) begin
                    result_q <= special_val_in;
                end
            end else if (state == CALC && !bus.flush) begin
                prod_q <= prod_next;
                cnt_q  <= cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_q <= calc_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: spec vectors from a table, random
// operations against a 64-bit arithmetic reference model, and hand-written
// sequences for busy-start, flush and asynchronous reset.
module tb_muldiv_seq;
    localparam int          XLEN    = 32;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    muldiv_seq_if #(.XLEN(XLEN)) bus ();

    muldiv_seq #(.XLEN(XLEN), .FAST_SPEC(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] expq[$];
    logic [31:0] lastExp = '0;
    vec_t        vecs[14];

    // Reference result using wide native arithmetic.
    function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        int                 sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return sp[63:32]; end
            3'd2: begin sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return MIN_NEG;
                return 32'(sa / sb);
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int refLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Drive one request from just after a falling edge; it is accepted at the next rising edge.
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp, input bit push);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        if (push) expq.push_back(exp);
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int lat, input string name, input bit pester);
        int          cycles     = 0;
        int          busyCycles = 0;
        bit          seen       = 1'b0;
        logic [31:0] want;
        applyStimulus(op, a, b, exp, 1'b1);
        while (!seen && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                seen = 1'b1;
                checkOutput({name, "_done"}, {31'b0, seen}, 32'd1);
                want = expq.pop_front();
                checkOutput({name, "_result"}, bus.result, want);
                checkOutput({name, "_latency"}, 32'(cycles), 32'(lat));
                checkOutput({name, "_busy"}, 32'(busyCycles), 32'(lat));
                if (pester) bus.start = 1'b1;
            end else if (pester) begin
                bus.start = cycles[0];
                bus.op    = 3'($urandom_range(0, 7));
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
        end
        if (!seen) begin
            checkOutput({name, "_done"}, {31'b0, seen}, 32'd1);
            if (expq.size() > 0) void'(expq.pop_front());
        end
        @(negedge clk);
        checkOutput({name, "_after"}, {30'b0, bus.busy, bus.done}, 32'd0);
        bus.start = 1'b0;
        lastExp   = exp;
    endtask

    task automatic watchNoDone(input int n, input string name);
        int cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
        checkOutput(name, 32'(cnt), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'b001, MIN_NEG,       MIN_NEG,       32'h4000_0000, 33};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'b100, 32'd1234,      32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'b110, 32'd5,         32'd0,         32'd5,         1};
        vecs[10] = '{3'b100, MIN_NEG,       32'hFFFF_FFFF, MIN_NEG,       1};
        vecs[11] = '{3'b110, MIN_NEG,       32'hFFFF_FFFF, 32'd0,         1};
        vecs[12] = '{3'b101, 32'd9,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'b111, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};

        bus.start = 1'b0;
        bus.flush = 1'b0;
        bus.op    = '0;
        bus.a     = '0;
        bus.b     = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy",   {31'b0, bus.busy}, 32'd0);
        checkOutput("reset_done",   {31'b0, bus.done}, 32'd0);
        checkOutput("reset_result", bus.result,        32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] specification vectors");
        for (int i = 0; i < 14; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat,
                  $sformatf("vec%0d", i), 1'b0);
        end

        $display("[TB] start pulses while busy and in the done cycle");
        runOp(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "pester", 1'b1);
        watchNoDone(40, "pester_no_extra_done");

        $display("[TB] flush mid-calculation");
        applyStimulus(3'b101, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_busy",   {31'b0, bus.busy}, 32'd0);
        checkOutput("flush_done",   {31'b0, bus.done}, 32'd0);
        checkOutput("flush_result", bus.result,        lastExp);
        runOp(3'b101, 32'd1000, 32'd3, 32'd333, 33, "after_flush", 1'b0);

        $display("[TB] flush and start together in idle");
        bus.flush = 1'b1;
        applyStimulus(3'b000, 32'd3, 32'd4, 32'd12, 1'b0);
        bus.flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_start_busy", {31'b0, bus.busy}, 32'd0);
        watchNoDone(40, "flush_start_no_done");

        $display("[TB] asynchronous reset mid-calculation");
        applyStimulus(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("areset_busy",   {31'b0, bus.busy}, 32'd0);
        checkOutput("areset_done",   {31'b0, bus.done}, 32'd0);
        checkOutput("areset_result", bus.result,        32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        lastExp = '0;
        watchNoDone(40, "areset_no_done");

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if (i % 6 == 0) rb = '0;
            if (i % 6 == 3) begin
                rop = (i % 12 == 3) ? 3'b100 : 3'b110;
                ra  = MIN_NEG;
                rb  = 32'hFFFF_FFFF;
            end
            if (i % 6 == 4) rb = 32'($urandom_range(1, 9));
            runOp(rop, ra, rb, refModel(rop, ra, rb), refLat(rop, ra, rb),
                  $sformatf("rand%0d_op%0d", i, rop), 1'b0);
        end

        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
